// File: rtl/map_responder.sv
// Tile-map server for the tank game: 2-bit tile RAM with VGA and collision read
// ports, default-map loader, and a hit FIFO that clears struck bricks.
module map_responder #(
    parameter int unsigned MAP_W     = 40,
    parameter int unsigned MAP_H     = 30,
    parameter int unsigned HIT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    output logic        o_ready,
    input  logic        i_req_valid,
    input  logic [5:0]  i_req_x,
    input  logic [5:0]  i_req_y,
    output logic        o_rsp_valid,
    output logic [1:0]  o_rsp_tile,
    input  logic        i_q_valid,
    input  logic [5:0]  i_q_x,
    input  logic [5:0]  i_q_y,
    output logic        o_q_valid,
    output logic [1:0]  o_q_tile,
    input  logic        i_hit_valid,
    input  logic [5:0]  i_hit_x,
    input  logic [5:0]  i_hit_y,
    output logic        o_hit_full,
    output logic [10:0] o_brick_count
);

    localparam int unsigned CELLS = MAP_W * MAP_H;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned PW    = (HIT_DEPTH > 1) ? $clog2(HIT_DEPTH) : 1;
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned BW    = 11;

    localparam logic [5:0]    X_LIM     = 6'(MAP_W);
    localparam logic [5:0]    Y_LIM     = 6'(MAP_H);
    localparam logic [5:0]    X_LAST    = 6'(MAP_W - 1);
    localparam logic [5:0]    Y_LAST    = 6'(MAP_H - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(HIT_DEPTH);

    localparam logic [1:0] T_EMPTY = 2'd0;
    localparam logic [1:0] T_BRICK = 2'd1;
    localparam logic [1:0] T_STEEL = 2'd2;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e        state_q;
    logic [AW-1:0] init_addr_q;
    logic [5:0]    init_x_q, init_y_q;
    logic          ready_q;
    logic          rsp_valid_q, q_valid_q;
    logic [1:0]    rsp_tile_q, q_tile_q;
    logic [5:0]    fifo_x_q [HIT_DEPTH];
    logic [5:0]    fifo_y_q [HIT_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;
    logic          hit_wr_q;
    logic [AW-1:0] hit_addr_q;
    logic [1:0]    hit_tile_q;
    logic [BW-1:0] brick_q;
    logic [1:0]    mem_q [CELLS];

    logic          q_acc_c, hit_rd_c, push_c, rd_oor_c, wr_en_c;
    logic [5:0]    rd_x_c, rd_y_c;
    logic [AW-1:0] rd_addr_c, wr_addr_c;
    logic [1:0]    wr_data_c, rd_data_c, rd_tile_c, init_tile_c;

    function automatic logic [1:0] default_tile(input logic [5:0] x, input logic [5:0] y);
        if (x == 6'd0 || x == X_LAST || y == 6'd0 || y == Y_LAST) return T_STEEL;
        if (x[2:0] == 3'd4 && y[1]) return T_BRICK;
        return T_EMPTY;
    endfunction

    // Read-port arbitration (VGA > query > hit drain) and write-port selection
    always_comb begin
        q_acc_c  = i_q_valid && !i_req_valid && !q_valid_q;
        hit_rd_c = (state_q == ST_RUN) && !i_init && !i_req_valid && !q_acc_c
                   && (cnt_q != '0) && !hit_wr_q;
        push_c   = i_hit_valid && (!full_q || hit_rd_c);
        cnt_d    = cnt_q + CW'(push_c) - CW'(hit_rd_c);

        rd_x_c = fifo_x_q[rd_ptr_q];
        rd_y_c = fifo_y_q[rd_ptr_q];
        if (i_req_valid) begin
            rd_x_c = i_req_x;
            rd_y_c = i_req_y;
        end else if (q_acc_c) begin
            rd_x_c = i_q_x;
            rd_y_c = i_q_y;
        end
        rd_oor_c  = (rd_x_c >= X_LIM) || (rd_y_c >= Y_LIM);
        rd_addr_c = rd_oor_c ? '0 : AW'(rd_y_c) * AW'(MAP_W) + AW'(rd_x_c);

        init_tile_c = default_tile(init_x_q, init_y_q);
        wr_en_c     = 1'b0;
        wr_addr_c   = init_addr_q;
        wr_data_c   = init_tile_c;
        if (!i_init) begin
            if (state_q == ST_INIT) begin
                wr_en_c = 1'b1;
            end else if (hit_wr_q && hit_tile_q == T_BRICK) begin
                wr_en_c   = 1'b1;
                wr_addr_c = hit_addr_q;
                wr_data_c = T_EMPTY;
            end
        end

        // A clear landing this cycle is visible to a read of the same tile
        rd_data_c = (wr_en_c && wr_addr_c == rd_addr_c) ? wr_data_c : mem_q[rd_addr_c];
        rd_tile_c = (rd_oor_c || state_q == ST_INIT) ? T_STEEL : rd_data_c;
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_addr_c] <= wr_data_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_x_q    <= '0;
            init_y_q    <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tile_q  <= T_EMPTY;
            q_valid_q   <= 1'b0;
            q_tile_q    <= T_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            hit_wr_q    <= 1'b0;
            hit_addr_q  <= '0;
            hit_tile_q  <= T_EMPTY;
            brick_q     <= '0;
            for (int i = 0; i < int'(HIT_DEPTH); i++) begin
                fifo_x_q[i] <= '0;
                fifo_y_q[i] <= '0;
            end
        end else begin
            rsp_valid_q <= i_req_valid;
            if (i_req_valid) rsp_tile_q <= rd_tile_c;
            q_valid_q <= q_acc_c;
            if (q_acc_c) q_tile_q <= rd_tile_c;

            if (i_init) begin
                state_q     <= ST_INIT;
                init_addr_q <= '0;
                init_x_q    <= '0;
                init_y_q    <= '0;
                ready_q     <= 1'b0;
                brick_q     <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                cnt_q       <= '0;
                full_q      <= 1'b0;
                hit_wr_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        brick_q <= brick_q + BW'(init_tile_c == T_BRICK);
                        if (init_addr_q == LAST_ADDR) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            init_addr_q <= init_addr_q + AW'(1);
                            if (init_x_q == X_LAST) begin
                                init_x_q <= '0;
                                init_y_q <= init_y_q + 6'd1;
                            end else begin
                                init_x_q <= init_x_q + 6'd1;
                            end
                        end
                    end
                    ST_RUN: begin
                        hit_wr_q <= hit_rd_c;
                        if (hit_rd_c) begin
                            hit_addr_q <= rd_addr_c;
                            hit_tile_q <= rd_tile_c;
                            rd_ptr_q   <= rd_ptr_q + PW'(1);
                        end
                        if (push_c) begin
                            fifo_x_q[wr_ptr_q] <= i_hit_x;
                            fifo_y_q[wr_ptr_q] <= i_hit_y;
                            wr_ptr_q           <= wr_ptr_q + PW'(1);
                        end
                        cnt_q  <= cnt_d;
                        full_q <= (cnt_d == DEPTH);
                        if (hit_wr_q && hit_tile_q == T_BRICK && brick_q != '0)
                            brick_q <= brick_q - BW'(1);
                    end
                endcase
            end
        end
    end

    assign o_ready       = ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_tile    = rsp_tile_q;
    assign o_q_valid     = q_valid_q;
    assign o_q_tile      = q_tile_q;
    assign o_hit_full    = full_q;
    assign o_brick_count = brick_q;

endmodule

// File: doc/map_responder.md
Name: map_responder

Overview:
- Tile-map server for the tank game. Holds the 40x30 playfield tile map in on-chip RAM and answers per-tile read requests from the VGA renderer and from the game-state collision logic.
- Applies wall destruction reported by shell logic.
- Sits between VGA (initiator of tile requests) and the state/shell blocks. It is the responder end of the VGA request_x/request_y -> is_wall interface.

Parameters:
- MAP_W, 40, tiles per row (x range 0..MAP_W-1)
- MAP_H, 30, tiles per column (y range 0..MAP_H-1)
- HIT_DEPTH, 4, entries in hit FIFO (power of 2)

Ports:
- clk  in  1  25 MHz game clock
- rst  in  1  asynchronous, active-high reset
- i_init  in  1  pulse: reload default map
- o_ready  out  1  map loaded, normal service
- i_req_valid  in  1  VGA tile request
- i_req_x  in  6  VGA request column
- i_req_y  in  6  VGA request row
- o_rsp_valid  out  1  VGA response strobe
- o_rsp_tile  out  2  0 empty, 1 brick, 2 steel
- i_q_valid  in  1  collision query, held until o_q_valid
- i_q_x  in  6  query column
- i_q_y  in  6  query row
- o_q_valid  out  1  query response strobe
- o_q_tile  out  2  query tile
- i_hit_valid  in  1  shell struck tile
- i_hit_x  in  6  hit column
- i_hit_y  in  6  hit row
- o_hit_full  out  1  hit FIFO full
- o_brick_count  out  11  brick tiles remaining

Behaviour:
- Reset values: all outputs 0. FSM enters INIT with address counter 0. FIFO is empty.
- Address mapping: addr = y*MAP_W + x. RAM is simple dual-port, one read port and one write port, 2 bits wide.
- Out-of-range coordinates (x>=MAP_W or y>=MAP_H) respond steel (2), do not touch RAM, and keep the same latency.
- Default map:
  - Steel where x==0, x==MAP_W-1, y==0 or y==MAP_H-1.
  - Elsewhere brick where x[2:0]==4 and y[1]==1, else empty.
  - Defaults give 70 bricks.
- FSM states:
  - INIT: writes one default tile per cycle, addr 0..MAP_W*MAP_H-1. o_brick_count resets to 0 on entry and +1 per brick written. After the last write -> RUN and o_ready=1 the next cycle (1200 cycles for defaults).
  - RUN: normal service. i_init in RUN -> INIT, o_ready=0 the next cycle.
  - i_init during INIT restarts the counter at 0.
- During INIT:
  - VGA/query requests are answered steel with normal latency.
  - Hits are dropped and the FIFO is flushed.
- VGA port:
  - Highest read priority, never stalled.
  - o_rsp_valid/o_rsp_tile are valid exactly 1 cycle after i_req_valid.
- Query port:
  - Accepted on a cycle with i_q_valid=1 and i_req_valid=0.
  - o_q_valid pulses 1 cycle after acceptance, for one cycle.
  - Requester holds i_q_valid/i_q_x/i_q_y stable until o_q_valid; it may reassert the next cycle.
- Hit FIFO:
  - Push when i_hit_valid && !o_hit_full; a hit while full is discarded.
  - o_hit_full = count==HIT_DEPTH.
  - Simultaneous push and pop allowed, including when full.
  - Pointers wrap modulo HIT_DEPTH.
- Hit drain:
  - HIT_RD: uses the read port only on a cycle with no VGA request and no query accept. Pops the head entry.
  - HIT_WR (next cycle): if the read tile == brick, write empty and decrement o_brick_count. Otherwise no write.
  - Out-of-range hits pop with no effect.
  - Only one hit in flight at a time.
- Read-during-write to the same address returns the newly written value (forwarding). The returned value is empty for a hit clear.
- Steel is indestructible.
- o_brick_count never underflows.
- Reset asserted mid-operation aborts any in-flight access, empties the FIFO and restarts INIT.

Test Plan:
- Release rst, idle 1200 cycles -> o_ready rises at cycle 1201, o_brick_count=70. Query (0,5)->2, (4,2)->1, (5,2)->0.
- VGA request (12,3) every cycle for 10 cycles with a query held at (4,6) -> 10 VGA responses of 1, each 1 cycle later. The query is answered 1 only on the first VGA-free cycle.
- Hit (4,2) with idle ports -> next VGA read of (4,2) returns 0, o_brick_count=69. A second hit at the same tile leaves the count at 69. A hit on (0,0) leaves it steel.
- Push 5 hits on consecutive cycles with continuous VGA traffic -> o_hit_full after 4, 5th dropped. After VGA stops, 4 tiles clear and the count drops by 4.
- Request (45,10) and (10,31) -> tile 2, 1-cycle latency, no RAM effect.
- i_init in RUN after clears -> o_ready=0 next cycle, map restored, count back to 70. Assert rst mid-INIT -> outputs 0, INIT restarts from address 0.
